// File: rtl/nibble_serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// nibble_adder_pkg
// Shared constants and types for the nibble-serial adder:
//   NIBBLE_W        - width of one adder slice (fixed at 4 by the adder cell)
//   DEFAULT_NIBBLES - default slice count of the top level
//   state_e         - controller states
//   idx_width()     - index counter width for a given slice count
// -----------------------------------------------------------------------------
package nibble_adder_pkg;

  localparam int NIBBLE_W        = 4;
  localparam int DEFAULT_NIBBLES = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // The index must be able to hold NIBBLES itself (its value right after the
  // last slice), so it is sized for NIBBLES+1 codes and never wraps.
  function automatic int idx_width(input int nibbles);
    return $clog2(nibbles + 1);
  endfunction

  localparam int DEFAULT_IDX_W = idx_width(DEFAULT_NIBBLES);

endpackage : nibble_adder_pkg

// File: rtl/nibble_serial_adder_if.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder_if
// Request/result bundle between a controller (master) and the adder (slave).
//   start - request, sampled by the adder only while idle
//   a, b  - operands, W = NIBBLE_W*NIBBLES bits
//   cin   - carry into nibble 0
//   busy  - operation in progress
//   done  - one-cycle pulse, sum/cout valid
//   sum   - a + b + cin mod 2^W
//   cout  - carry out of the top nibble
// -----------------------------------------------------------------------------
interface nibble_serial_adder_if
  import nibble_adder_pkg::*;
#(
  parameter int NIBBLES = DEFAULT_NIBBLES
);

  localparam int W = NIBBLE_W * NIBBLES;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );

endinterface : nibble_serial_adder_if

// File: rtl/four_bit_full_adder.sv
// -----------------------------------------------------------------------------
// four_bit_full_adder
// Gate-level 4-bit ripple-carry adder built from four full-adder cells.
//   a_i, b_i - 4-bit operands
//   cin_i    - carry in
//   sum_o    - 4-bit sum
//   cout_o   - carry out
// -----------------------------------------------------------------------------
module four_bit_full_adder (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o
);

  logic [4:0] c;
  logic [3:0] p;

  assign c[0] = cin_i;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign p[i]     = a_i[i] ^ b_i[i];
    assign sum_o[i] = p[i] ^ c[i];
    assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & p[i]);
  end

  assign cout_o = c[4];

endmodule : four_bit_full_adder

// File: rtl/nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder
// Computes {cout,sum} = a + b + cin one nibble per clock, LSB nibble first,
// through a single four_bit_full_adder with a registered inter-nibble carry.
// Latency is NIBBLES cycles from accept to the done pulse.
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - slave side of nibble_serial_adder_if (start/a/b/cin in,
//           busy/done/sum/cout out)
// -----------------------------------------------------------------------------
module nibble_serial_adder
  import nibble_adder_pkg::*;
#(
  parameter int NIBBLES = DEFAULT_NIBBLES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  nibble_serial_adder_if.slave  bus
);

  localparam int IDX_W = idx_width(NIBBLES);

  typedef logic [NIBBLES-1:0][NIBBLE_W-1:0] nib_vec_t;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q,   idx_d;
  logic             carry_q, carry_d;
  nib_vec_t         a_q,     a_d;
  nib_vec_t         b_q,     b_d;
  nib_vec_t         sum_q,   sum_d;
  logic             cout_q,  cout_d;
  logic             done_q,  done_d;

  logic [NIBBLE_W-1:0] add_a, add_b, add_s;
  logic                add_co;
  logic                last_nib;

  // Select the operand nibbles for the current index. A compare-per-slice
  // mux avoids indexing the nibble array with a wider-than-needed counter.
  always_comb begin
    add_a = '0;
    add_b = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        add_a = a_q[i];
        add_b = b_q[i];
      end
    end
  end

  four_bit_full_adder u_add (
    .a_i    (add_a),
    .b_i    (add_b),
    .cin_i  (carry_q),
    .sum_o  (add_s),
    .cout_o (add_co)
  );

  assign last_nib = (idx_q == IDX_W'(NIBBLES - 1));

  // Next-state and datapath update.
  always_comb begin
    // NOTE: every signal gets a hold/default value first so no path through
    // the case leaves one unassigned, which would infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.cin;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          state_d = RUN;
        end
      end

      RUN: begin
        for (int i = 0; i < NIBBLES; i++) begin
          if (idx_q == IDX_W'(i)) begin
            sum_d[i] = add_s;
          end
        end
        carry_d = add_co;
        idx_d   = idx_q + IDX_W'(1);
        if (last_nib) begin
          cout_d  = add_co;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      // NOTE: the operand registers are reset too, so a post-reset
      // idle adder never presents stale operands from an aborted run.
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule : nibble_serial_adder

// File: tb/tb_nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_nibble_serial_adder
// Self-checking bench for nibble_serial_adder with NIBBLES=4 (W=16).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_nibble_serial_adder;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic clk;
  logic rst_n;

  int total = 0;
  int bad   = 0;

  nibble_serial_adder_if #(.NIBBLES(NIB)) bus ();

  nibble_serial_adder #(.NIBBLES(NIB)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Walks the NIBBLES edges after an accept: busy must stay high and done low
  // until the last edge, where done pulses with the expected result. With
  // tail set, the following cycle must show done low and the result held.
  task automatic wait_result(input string tag, input logic [W-1:0] exp_s,
                             input logic exp_c, input bit tail);
    for (int k = 1; k <= NIB; k++) begin
      tick();
      if (k < NIB) begin
        check({tag, " busy mid"}, 32'(bus.busy), 32'd1);
        check({tag, " done early"}, 32'(bus.done), 32'd0);
      end else begin
        check({tag, " done"}, 32'(bus.done), 32'd1);
        check({tag, " busy at done"}, 32'(bus.busy), 32'd0);
        check({tag, " sum"}, 32'(bus.sum), 32'(exp_s));
        check({tag, " cout"}, 32'(bus.cout), 32'(exp_c));
      end
    end
    if (tail) begin
      tick();
      check({tag, " done width"}, 32'(bus.done), 32'd0);
      check({tag, " sum hold"}, 32'(bus.sum), 32'(exp_s));
    end
  endtask

  // One full operation; operand inputs are scrambled right after accept to
  // show only the latched copies matter.
  task automatic run_op(input string tag, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic cin,
                        input logic [W-1:0] exp_s, input logic exp_c);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.cin   = cin;
    tick();
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
    bus.cin   = 1'($urandom);
    check({tag, " busy after accept"}, 32'(bus.busy), 32'd1);
    check({tag, " sum cleared"}, 32'(bus.sum), 32'd0);
    check({tag, " cout cleared"}, 32'(bus.cout), 32'd0);
    wait_result(tag, exp_s, exp_c, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W:0] ref_full;
    logic [W-1:0] ra, rb;
    logic rc;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
    vecs[2] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vecs[3] = '{16'h0009, 16'h0008, 1'b1, 16'h0012, 1'b0};
    vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[5] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;

    // Reset state, before any clock edge.
    #2;
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset sum", 32'(bus.sum), 32'd0);
    check("reset cout", 32'(bus.cout), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("idle busy", 32'(bus.busy), 32'd0);

    // Directed vector table.
    for (int i = 0; i < 6; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
             vecs[i].exp_sum, vecs[i].exp_cout);
    end

    // Back-to-back: start held through the done cycle; the second operands
    // are presented while busy and must not disturb the first operation.
    bus.start = 1'b1;
    bus.a     = 16'h8000;
    bus.b     = 16'h8000;
    bus.cin   = 1'b0;
    tick();
    bus.a   = 16'h0009;
    bus.b   = 16'h0008;
    bus.cin = 1'b1;
    wait_result("b2b first", 16'h0000, 1'b1, 1'b0);
    tick();
    bus.start = 1'b0;
    check("b2b second accepted", 32'(bus.busy), 32'd1);
    check("b2b second done low", 32'(bus.done), 32'd0);
    check("b2b sum cleared", 32'(bus.sum), 32'd0);
    wait_result("b2b second", 16'h0012, 1'b0, 1'b1);

    // start pulsed while busy is ignored.
    bus.start = 1'b1;
    bus.a     = 16'h1111;
    bus.b     = 16'h1111;
    bus.cin   = 1'b0;
    tick();
    bus.start = 1'b0;
    tick();
    check("ign busy c1", 32'(bus.busy), 32'd1);
    bus.start = 1'b1;
    bus.a     = 16'hFFFF;
    tick();
    bus.start = 1'b0;
    check("ign busy c2", 32'(bus.busy), 32'd1);
    tick();
    check("ign busy c3", 32'(bus.busy), 32'd1);
    check("ign done c3", 32'(bus.done), 32'd0);
    tick();
    check("ign done", 32'(bus.done), 32'd1);
    check("ign sum", 32'(bus.sum), 32'h2222);
    check("ign cout", 32'(bus.cout), 32'd0);
    tick();
    check("ign idle after", 32'(bus.busy), 32'd0);
    check("ign done width", 32'(bus.done), 32'd0);

    // Asynchronous reset between edges in the middle of a run.
    bus.start = 1'b1;
    bus.a     = 16'h7777;
    bus.b     = 16'h7777;
    bus.cin   = 1'b0;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst busy", 32'(bus.busy), 32'd0);
    check("arst done", 32'(bus.done), 32'd0);
    check("arst sum", 32'(bus.sum), 32'd0);
    check("arst cout", 32'(bus.cout), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < NIB + 1; k++) begin
      tick();
      check("arst no done", 32'(bus.done), 32'd0);
      check("arst stays idle", 32'(bus.busy), 32'd0);
    end
    run_op("post arst", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0);

    // Random operands against plain integer addition.
    for (int n = 0; n < 1000; n++) begin
      ra       = W'($urandom);
      rb       = W'($urandom);
      rc       = 1'($urandom);
      ref_full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      run_op($sformatf("rnd%0d", n), ra, rb, rc, ref_full[W-1:0], ref_full[W]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_nibble_serial_adder

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
Multi-cycle wide adder that computes a + b + cin one nibble per clock, LSB nibble first. It drives a single instance of the existing gate-level four_bit_full_adder and keeps the inter-nibble carry in a register. It trades latency for area ahead of the datapath, and uses a start/busy/done handshake towards the controller.

Parameters:
- NIBBLES, 4, number of 4-bit slices; operand width W = 4*NIBBLES (legal range 2..16).

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, request; sampled only while idle.
- a, input, W, augend; captured on accept.
- b, input, W, addend; captured on accept.
- cin, input, 1, carry-in to nibble 0; captured on accept.
- busy, output, 1, high while an operation is in progress.
- done, output, 1, single-cycle pulse; result valid.
- sum, output, W, result a + b + cin mod 2^W.
- cout, output, 1, carry-out of the top nibble.

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset: takes effect immediately regardless of clk.
  - Outputs: busy=0, done=0, sum=0, cout=0.
  - Internal: state=IDLE, nibble index=0, carry register=0, operand registers=0.
  - Reset mid-operation aborts the operation silently; no done pulse.
- States: IDLE and RUN.
- Accept (edge E0): in IDLE with start=1.
  - Latch a, b, cin; index=0; carry register=cin.
  - Clear sum=0 and cout=0; enter RUN; busy=1.
- RUN, each edge Ek (k=1..NIBBLES):
  - The adder sees a_reg[4i+3:4i], b_reg[4i+3:4i] and the carry register, where i=k-1.
  - sum[4i+3:4i] <= adder sum; carry register <= adder cout; index++.
- Completion (edge E_NIBBLES):
  - cout <= adder cout; state -> IDLE; busy=0; done=1 for exactly one cycle.
  - Latency is NIBBLES cycles from accept to done.
- Holding results: sum and cout hold their values until the next accept or reset. Intermediate sum nibbles are visible during RUN but are not valid until done.
- start while busy=1 is ignored; it is neither queued nor able to corrupt the operands.
- start high during the done cycle is accepted at the next edge, giving back-to-back operation with no dead cycle beyond done.
- Operand inputs may change freely after accept; only the latched copies are used.
- Arithmetic: pure unsigned addition; {cout,sum} = a + b + cin, (W+1) bits. No overflow flag.
- The index counter is ceil(log2(NIBBLES+1)) bits and never wraps within an operation.

Decomposition:
- Package nibble_adder_pkg:
  - NIBBLE_W=4
  - state enum {IDLE, RUN}
  - default NIBBLES
  - width of the index counter derived from NIBBLES
- Sub-module: the existing four_bit_full_adder, instantiated once, combinationally between the operand and carry registers and the sum/carry registers. No other sub-modules.
- The FSM, index counter, and operand, carry and sum registers live in the top module.

Test Plan (NIBBLES=4):
- a=0x1234, b=0x4321, cin=0, start for 1 cycle:
  - busy high 4 cycles, done pulses on the 4th edge after accept, sum=0x5555, cout=0.
- a=0xFFFF, b=0x0000, cin=1:
  - carry ripples through all four nibbles; sum=0x0000, cout=1.
- a=0x8000, b=0x8000, cin=0:
  - sum=0x0000, cout=1.
  - Then a=0x0009, b=0x0008, cin=1 back-to-back with start held through the done cycle: second result 0x0012, cout=0, accepted on the edge after done.
- Start 0x1111+0x1111 and pulse start again with a=0xFFFF at cycle 2:
  - second request ignored; result 0x2222, cout=0; busy never drops early.
- Assert rst_n=0 asynchronously mid-RUN (between edges) on 0x7777+0x7777:
  - all outputs 0 immediately, no done.
  - After release, a new start of 0x0001+0x0001 gives 0x0002.
- Exhaustive/random compare over 1000 random {a,b,cin}: {cout,sum} must match a+b+cin at every done; done must be exactly one cycle wide.
